// File: rtl/pwr_relay_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pwr_relay_sequencer
//  Description : Executor-side relay sequencer for the power-control CPLD.
//                Builds the L-active relay request word and the three imax
//                timeout bytes, ramping UUT power one channel at a time
//                (GND first on the way up, GND last on the way down) and
//                dropping every request when the CPLD raises a power fail.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwr_relay_sequencer #(
    parameter int         STEP_TICKS  = 10,
    parameter logic [7:0] TIMEOUT_DEF = 8'd50
) (
    input  logic       clk_timer,
    input  logic       reset_2,
    input  logic       start,
    input  logic       stop,
    input  logic       clear_fault,
    input  logic [3:0] req_mask,
    input  logic [7:0] timeout_cfg,
    input  logic       uut_pwr_fail,
    output logic [3:0] pwr_relays_n,
    output logic [7:0] imax_timeout_1,
    output logic [7:0] imax_timeout_2,
    output logic [7:0] imax_timeout_3,
    output logic       busy,
    output logic       pwr_on,
    output logic       fault
);

    // Reload value of the step counter: a channel holds for STEP_TICKS ticks.
    localparam logic [7:0] C_STEP_LOAD = 8'(STEP_TICKS - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARM       = 3'd1,
        ST_RAMP_UP   = 3'd2,
        ST_ON        = 3'd3,
        ST_RAMP_DOWN = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

    // Channel order on the way up: GND, PWR_1, PWR_2, PWR_3.
    function automatic logic [1:0] f_up_map(input logic [1:0] idx);
        case (idx)
            2'd0:    f_up_map = 2'd3;
            2'd1:    f_up_map = 2'd0;
            2'd2:    f_up_map = 2'd1;
            default: f_up_map = 2'd2;
        endcase
    endfunction

    // Channel order on the way down: PWR_3, PWR_2, PWR_1, GND.
    function automatic logic [1:0] f_down_map(input logic [1:0] idx);
        case (idx)
            2'd0:    f_down_map = 2'd2;
            2'd1:    f_down_map = 2'd1;
            2'd2:    f_down_map = 2'd0;
            default: f_down_map = 2'd3;
        endcase
    endfunction

    // Status flags {busy, pwr_on, fault} belonging to a state.
    function automatic logic [2:0] f_flags(input state_t s);
        f_flags = {(s == ST_ARM) || (s == ST_RAMP_UP) || (s == ST_RAMP_DOWN),
                   (s == ST_ON),
                   (s == ST_FAULT)};
    endfunction

    state_t     r_state;
    logic [1:0] r_idx;
    logic [7:0] r_cnt;
    logic [3:0] r_mask;
    logic [3:0] r_relays_n;
    logic [7:0] r_tmo;
    logic       r_busy;
    logic       r_pwr_on;
    logic       r_fault;
    logic       r_fail_meta;
    logic       r_fail_s;

    logic [1:0] w_idx_next;
    logic [1:0] w_up_nbit;
    logic [1:0] w_dn_nbit;

    // Bit that becomes active when the ramp advances to the next index.
    assign w_idx_next = r_idx + 2'd1;
    assign w_up_nbit  = f_up_map(w_idx_next);
    assign w_dn_nbit  = f_down_map(w_idx_next);

    // Two-stage synchroniser for the asynchronous power-fail alert.
    always_ff @(posedge clk_timer or negedge reset_2) begin
        if (!reset_2) begin
            r_fail_meta <= 1'b0;
            r_fail_s    <= 1'b0;
        end else begin
            r_fail_meta <= uut_pwr_fail;
            r_fail_s    <= r_fail_meta;
        end
    end

    // Sequencer: state, ramp index, step counter and all registered outputs.
    always_ff @(posedge clk_timer or negedge reset_2) begin
        if (!reset_2) begin
            r_state                       <= ST_IDLE;
            r_idx                         <= 2'd0;
            r_cnt                         <= 8'd0;
            r_mask                        <= 4'd0;
            r_relays_n                    <= 4'hF;
            r_tmo                         <= TIMEOUT_DEF;
            {r_busy, r_pwr_on, r_fault}   <= 3'b000;
        end else if (r_fail_s && (r_state != ST_IDLE)) begin
            // Power fail overrides everything: drop all requests this tick.
            r_state                       <= ST_FAULT;
            r_relays_n                    <= 4'hF;
            r_idx                         <= 2'd0;
            r_cnt                         <= 8'd0;
            {r_busy, r_pwr_on, r_fault}   <= f_flags(ST_FAULT);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!stop && start && (req_mask != 4'd0)) begin
                        r_mask                      <= req_mask;
                        r_tmo                       <= timeout_cfg;
                        r_state                     <= ST_ARM;
                        {r_busy, r_pwr_on, r_fault} <= f_flags(ST_ARM);
                    end
                end
                ST_ARM: begin
                    // Timeouts are already on the bus; request GND if selected.
                    r_state <= ST_RAMP_UP;
                    r_idx   <= 2'd0;
                    if (stop) begin
                        r_state <= ST_RAMP_DOWN;
                        r_cnt   <= 8'd0;
                    end else if (r_mask[3]) begin
                        r_relays_n[3] <= 1'b0;
                        r_cnt         <= C_STEP_LOAD;
                    end else begin
                        r_cnt <= 8'd0;
                    end
                end
                ST_RAMP_UP: begin
                    if (stop) begin
                        // Reverse from wherever the ramp has got to.
                        r_state <= ST_RAMP_DOWN;
                        r_idx   <= 2'd0;
                        if (!r_relays_n[2]) begin
                            r_relays_n[2] <= 1'b1;
                            r_cnt         <= C_STEP_LOAD;
                        end else begin
                            r_cnt <= 8'd0;
                        end
                    end else if (r_cnt != 8'd0) begin
                        r_cnt <= r_cnt - 8'd1;
                    end else if (r_idx == 2'd3) begin
                        r_state                     <= ST_ON;
                        {r_busy, r_pwr_on, r_fault} <= f_flags(ST_ON);
                    end else begin
                        r_idx <= w_idx_next;
                        if (r_mask[w_up_nbit]) begin
                            r_relays_n[w_up_nbit] <= 1'b0;
                            r_cnt                 <= C_STEP_LOAD;
                        end else begin
                            r_cnt <= 8'd0;
                        end
                    end
                end
                ST_ON: begin
                    if (stop) begin
                        r_state                     <= ST_RAMP_DOWN;
                        r_idx                       <= 2'd0;
                        {r_busy, r_pwr_on, r_fault} <= f_flags(ST_RAMP_DOWN);
                        if (!r_relays_n[2]) begin
                            r_relays_n[2] <= 1'b1;
                            r_cnt         <= C_STEP_LOAD;
                        end else begin
                            r_cnt <= 8'd0;
                        end
                    end
                end
                ST_RAMP_DOWN: begin
                    if (r_cnt != 8'd0) begin
                        r_cnt <= r_cnt - 8'd1;
                    end else if (r_idx == 2'd3) begin
                        r_state                     <= ST_IDLE;
                        r_idx                       <= 2'd0;
                        r_relays_n                  <= 4'hF;
                        {r_busy, r_pwr_on, r_fault} <= f_flags(ST_IDLE);
                    end else begin
                        // Only channels that are actually on cost a full step.
                        r_idx <= w_idx_next;
                        if (!r_relays_n[w_dn_nbit]) begin
                            r_relays_n[w_dn_nbit] <= 1'b1;
                            r_cnt                 <= C_STEP_LOAD;
                        end else begin
                            r_cnt <= 8'd0;
                        end
                    end
                end
                ST_FAULT: begin
                    if (clear_fault) begin
                        r_state                     <= ST_IDLE;
                        {r_busy, r_pwr_on, r_fault} <= f_flags(ST_IDLE);
                    end
                end
                default: begin
                    r_state                     <= ST_IDLE;
                    r_relays_n                  <= 4'hF;
                    {r_busy, r_pwr_on, r_fault} <= f_flags(ST_IDLE);
                end
            endcase
        end
    end

    assign pwr_relays_n   = r_relays_n;
    assign imax_timeout_1 = r_tmo;
    assign imax_timeout_2 = r_tmo;
    assign imax_timeout_3 = r_tmo;
    assign busy           = r_busy;
    assign pwr_on         = r_pwr_on;
    assign fault          = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_pwr_relay_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwr_relay_sequencer
//  Description : Directed self-checking bench for pwr_relay_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwr_relay_sequencer;

    logic       clk_timer;
    logic       reset_2;
    logic       start;
    logic       stop;
    logic       clear_fault;
    logic [3:0] req_mask;
    logic [7:0] timeout_cfg;
    logic       uut_pwr_fail;
    logic [3:0] pwr_relays_n;
    logic [7:0] imax_timeout_1;
    logic [7:0] imax_timeout_2;
    logic [7:0] imax_timeout_3;
    logic       busy;
    logic       pwr_on;
    logic       fault;

    int n_checks = 0;
    int n_fail   = 0;

    pwr_relay_sequencer #(
        .STEP_TICKS  (10),
        .TIMEOUT_DEF (8'd50)
    ) dut (
        .clk_timer      (clk_timer),
        .reset_2        (reset_2),
        .start          (start),
        .stop           (stop),
        .clear_fault    (clear_fault),
        .req_mask       (req_mask),
        .timeout_cfg    (timeout_cfg),
        .uut_pwr_fail   (uut_pwr_fail),
        .pwr_relays_n   (pwr_relays_n),
        .imax_timeout_1 (imax_timeout_1),
        .imax_timeout_2 (imax_timeout_2),
        .imax_timeout_3 (imax_timeout_3),
        .busy           (busy),
        .pwr_on         (pwr_on),
        .fault          (fault)
    );

    initial clk_timer = 1'b0;
    always #10 clk_timer = ~clk_timer;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk_timer);
        #1;
    endtask

    task automatic pulse_start(input logic [3:0] m, input logic [7:0] cfg);
        req_mask    = m;
        timeout_cfg = cfg;
        start       = 1'b1;
        tick(1);
        start       = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if (pwr_relays_n !== 4'hF) begin
            n_fail++; $display("FAIL reset_relays actual=%h expected=F", pwr_relays_n);
        end
        n_checks++;
        if ({imax_timeout_1, imax_timeout_2, imax_timeout_3} !== {3{8'd50}}) begin
            n_fail++; $display("FAIL reset_timeouts actual=%h/%h/%h expected=32",
                               imax_timeout_1, imax_timeout_2, imax_timeout_3);
        end
        n_checks++;
        if ({busy, pwr_on, fault} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags actual=%b expected=000", {busy, pwr_on, fault});
        end
    endtask

    // Full mask: GND, PWR_1, PWR_2, PWR_3 cleared 10 ticks apart.
    task automatic test_power_up();
        logic [3:0] exp_seq [3] = '{4'h6, 4'h4, 4'h0};
        logic [3:0] prev;
        pulse_start(4'hF, 8'h20);
        n_checks++;
        if ({imax_timeout_1, imax_timeout_2, imax_timeout_3} !== {3{8'h20}} ||
            pwr_relays_n !== 4'hF || busy !== 1'b1) begin
            n_fail++; $display("FAIL up_arm tmo=%h relays=%h busy=%b expected tmo=20 relays=F busy=1",
                               imax_timeout_1, pwr_relays_n, busy);
        end
        tick(1);
        n_checks++;
        if (pwr_relays_n !== 4'h7) begin
            n_fail++; $display("FAIL up_gnd actual=%h expected=7", pwr_relays_n);
        end
        prev = 4'h7;
        for (int i = 0; i < 3; i++) begin
            tick(9);
            n_checks++;
            if (pwr_relays_n !== prev) begin
                n_fail++; $display("FAIL up_hold%0d actual=%h expected=%h", i, pwr_relays_n, prev);
            end
            tick(1);
            n_checks++;
            if (pwr_relays_n !== exp_seq[i]) begin
                n_fail++; $display("FAIL up_step%0d actual=%h expected=%h", i, pwr_relays_n, exp_seq[i]);
            end
            prev = exp_seq[i];
        end
        tick(9);
        n_checks++;
        if (pwr_on !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL up_pre_on pwr_on=%b busy=%b expected 0/1", pwr_on, busy);
        end
        tick(1);
        n_checks++;
        if (pwr_on !== 1'b1 || busy !== 1'b0 || pwr_relays_n !== 4'h0) begin
            n_fail++; $display("FAIL up_on pwr_on=%b busy=%b relays=%h expected 1/0/0",
                               pwr_on, busy, pwr_relays_n);
        end
    endtask

    // From ON: PWR_3, PWR_2, PWR_1 then GND released 10 ticks apart.
    task automatic test_power_down();
        logic [3:0] exp_seq [4] = '{4'h4, 4'h6, 4'h7, 4'hF};
        pulse_stop();
        n_checks++;
        if (pwr_relays_n !== exp_seq[0] || busy !== 1'b1 || pwr_on !== 1'b0) begin
            n_fail++; $display("FAIL down_first relays=%h busy=%b pwr_on=%b expected 4/1/0",
                               pwr_relays_n, busy, pwr_on);
        end
        for (int i = 1; i < 4; i++) begin
            tick(10);
            n_checks++;
            if (pwr_relays_n !== exp_seq[i]) begin
                n_fail++; $display("FAIL down_step%0d actual=%h expected=%h", i, pwr_relays_n, exp_seq[i]);
            end
        end
        tick(9);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL down_busy_tail actual=%b expected=1", busy);
        end
        tick(1);
        n_checks++;
        if (busy !== 1'b0 || pwr_relays_n !== 4'hF || imax_timeout_2 !== 8'h20) begin
            n_fail++; $display("FAIL down_idle busy=%b relays=%h tmo=%h expected 0/F/20",
                               busy, pwr_relays_n, imax_timeout_2);
        end
    endtask

    // Mask 1010: only GND and PWR_2 wait; skipped channels cost one tick.
    task automatic test_sparse_mask();
        pulse_start(4'b1010, 8'h33);
        tick(1);
        n_checks++;
        if (pwr_relays_n !== 4'h7) begin
            n_fail++; $display("FAIL sparse_gnd actual=%h expected=7", pwr_relays_n);
        end
        tick(10);
        n_checks++;
        if (pwr_relays_n !== 4'h7) begin
            n_fail++; $display("FAIL sparse_skip1 actual=%h expected=7", pwr_relays_n);
        end
        tick(1);
        n_checks++;
        if (pwr_relays_n !== 4'h5) begin
            n_fail++; $display("FAIL sparse_pwr2 actual=%h expected=5", pwr_relays_n);
        end
        tick(10);
        n_checks++;
        if (pwr_on !== 1'b0) begin
            n_fail++; $display("FAIL sparse_pre_on actual=%b expected=0", pwr_on);
        end
        tick(1);
        n_checks++;
        if (pwr_on !== 1'b1 || imax_timeout_3 !== 8'h33) begin
            n_fail++; $display("FAIL sparse_on pwr_on=%b tmo=%h expected 1/33", pwr_on, imax_timeout_3);
        end
        pulse_stop();
        tick(1);
        n_checks++;
        if (pwr_relays_n !== 4'h7) begin
            n_fail++; $display("FAIL sparse_down_pwr2 actual=%h expected=7", pwr_relays_n);
        end
        tick(11);
        n_checks++;
        if (pwr_relays_n !== 4'hF || busy !== 1'b1) begin
            n_fail++; $display("FAIL sparse_down_gnd relays=%h busy=%b expected F/1", pwr_relays_n, busy);
        end
        tick(10);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL sparse_idle busy actual=%b expected=0", busy);
        end
    endtask

    task automatic test_fault();
        // A fail alert while idle changes nothing.
        uut_pwr_fail = 1'b1;
        tick(4);
        n_checks++;
        if (fault !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL fault_idle fault=%b busy=%b expected 0/0", fault, busy);
        end
        uut_pwr_fail = 1'b0;
        tick(3);
        pulse_start(4'hF, 8'h40);
        tick(11);
        n_checks++;
        if (pwr_relays_n !== 4'h6) begin
            n_fail++; $display("FAIL fault_pre relays actual=%h expected=6", pwr_relays_n);
        end
        uut_pwr_fail = 1'b1;
        tick(2);
        n_checks++;
        if (pwr_relays_n !== 4'h6 || fault !== 1'b0) begin
            n_fail++; $display("FAIL fault_sync relays=%h fault=%b expected 6/0", pwr_relays_n, fault);
        end
        tick(1);
        n_checks++;
        if (pwr_relays_n !== 4'hF || fault !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL fault_enter relays=%h fault=%b busy=%b expected F/1/0",
                               pwr_relays_n, fault, busy);
        end
        clear_fault = 1'b1;
        tick(1);
        clear_fault = 1'b0;
        n_checks++;
        if (fault !== 1'b1) begin
            n_fail++; $display("FAIL fault_clear_blocked actual=%b expected=1", fault);
        end
        uut_pwr_fail = 1'b0;
        tick(3);
        clear_fault = 1'b1;
        tick(1);
        clear_fault = 1'b0;
        n_checks++;
        if ({busy, pwr_on, fault} !== 3'b000 || pwr_relays_n !== 4'hF || imax_timeout_1 !== 8'h40) begin
            n_fail++; $display("FAIL fault_clear flags=%b relays=%h tmo=%h expected 000/F/40",
                               {busy, pwr_on, fault}, pwr_relays_n, imax_timeout_1);
        end
    endtask

    task automatic test_ignored_commands();
        start       = 1'b1;
        stop        = 1'b1;
        req_mask    = 4'hF;
        timeout_cfg = 8'h77;
        tick(1);
        start = 1'b0;
        stop  = 1'b0;
        tick(2);
        n_checks++;
        if (busy !== 1'b0 || pwr_relays_n !== 4'hF || imax_timeout_1 !== 8'h40) begin
            n_fail++; $display("FAIL start_stop_same busy=%b relays=%h tmo=%h expected 0/F/40",
                               busy, pwr_relays_n, imax_timeout_1);
        end
        pulse_start(4'h0, 8'h66);
        tick(2);
        n_checks++;
        if (busy !== 1'b0 || pwr_relays_n !== 4'hF || imax_timeout_2 !== 8'h40) begin
            n_fail++; $display("FAIL start_mask0 busy=%b relays=%h tmo=%h expected 0/F/40",
                               busy, pwr_relays_n, imax_timeout_2);
        end
    endtask

    // Stop while waiting on PWR_1: PWR_3/PWR_2 skipped, PWR_1 then GND released.
    task automatic test_stop_in_ramp();
        pulse_start(4'hF, 8'h10);
        tick(14);
        pulse_stop();
        n_checks++;
        if (pwr_relays_n !== 4'h6 || busy !== 1'b1) begin
            n_fail++; $display("FAIL abort_first relays=%h busy=%b expected 6/1", pwr_relays_n, busy);
        end
        tick(2);
        n_checks++;
        if (pwr_relays_n !== 4'h7) begin
            n_fail++; $display("FAIL abort_pwr1 actual=%h expected=7", pwr_relays_n);
        end
        tick(9);
        n_checks++;
        if (pwr_relays_n !== 4'h7) begin
            n_fail++; $display("FAIL abort_hold actual=%h expected=7", pwr_relays_n);
        end
        tick(1);
        n_checks++;
        if (pwr_relays_n !== 4'hF || busy !== 1'b1) begin
            n_fail++; $display("FAIL abort_gnd relays=%h busy=%b expected F/1", pwr_relays_n, busy);
        end
        tick(10);
        n_checks++;
        if (busy !== 1'b0 || pwr_on !== 1'b0) begin
            n_fail++; $display("FAIL abort_idle busy=%b pwr_on=%b expected 0/0", busy, pwr_on);
        end
    endtask

    task automatic test_async_reset();
        pulse_start(4'hF, 8'h55);
        tick(12);
        n_checks++;
        if (pwr_relays_n !== 4'h6) begin
            n_fail++; $display("FAIL rst_pre relays actual=%h expected=6", pwr_relays_n);
        end
        #3;
        reset_2 = 1'b0;
        #1;
        n_checks++;
        if (pwr_relays_n !== 4'hF || busy !== 1'b0 || imax_timeout_1 !== 8'd50) begin
            n_fail++; $display("FAIL rst_async relays=%h busy=%b tmo=%h expected F/0/32",
                               pwr_relays_n, busy, imax_timeout_1);
        end
        #2;
        reset_2 = 1'b1;
        tick(3);
        n_checks++;
        if ({busy, pwr_on, fault} !== 3'b000 || pwr_relays_n !== 4'hF) begin
            n_fail++; $display("FAIL rst_after flags=%b relays=%h expected 000/F",
                               {busy, pwr_on, fault}, pwr_relays_n);
        end
    endtask

    initial begin
        reset_2      = 1'b0;
        start        = 1'b0;
        stop         = 1'b0;
        clear_fault  = 1'b0;
        req_mask     = 4'h0;
        timeout_cfg  = 8'h00;
        uut_pwr_fail = 1'b0;
        #25;
        test_reset();
        reset_2 = 1'b1;
        tick(2);
        test_power_up();
        test_power_down();
        test_sparse_mask();
        test_fault();
        test_ignored_commands();
        test_stop_in_ramp();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
